fixed_predictor: RTL and testbench

- Downstream stage of the residual decoder. Rebuilds PCM samples of one FLAC FIXED subframe from warm-up samples and decoded residuals.
- Applies the FLAC fixed polynomial predictor, orders 0-4, one sample per accepted input.
- Output feeds the channel decorrelation / output buffer stage.
- Parameters are reloaded by asserting iRst before each subframe.

---
 rtl/fixed_predictor.sv | 176 +++++++++++++++++
 tb/tb_fixed_predictor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_predictor.sv
// FLAC FIXED subframe reconstruction: warm-up passthrough, then order 0-4 prediction.
// Define FIXED_PRED_SAT_EN to clamp out-of-range predictions and flag oOverflow.
module fixed_predictor #(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 20
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic [2:0]          iOrder,
    input  logic [15:0]         iBlockSize,
    input  logic [SAMPLE_W-1:0] iData,
    input  logic                iValid,
    output logic [SAMPLE_W-1:0] oSample,
    output logic                oValid,
    output logic                oDone,
    output logic                oError,
    output logic                oOverflow
);

    localparam int EXT_W = ACC_W - SAMPLE_W;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        PREDICT,
        DONE
    } state_t;

    state_t              state, stateNext;
    logic [2:0]          order;
    logic [15:0]         blockSize;
    logic [15:0]         cnt, cntNext, cntInc;
    logic [SAMPLE_W-1:0] s1, s2, s3, s4;
    logic [SAMPLE_W-1:0] s1Next, s2Next, s3Next, s4Next;
    logic [SAMPLE_W-1:0] sampleNext, predVal;
    logic                validNext, doneNext, errorNext;
    logic                predAccept;

    logic signed [ACC_W-1:0] xr, x1, x2, x3, x4, acc;

    function automatic logic signed [ACC_W-1:0] ext(input logic [SAMPLE_W-1:0] v);
        return {{EXT_W{v[SAMPLE_W-1]}}, v};
    endfunction

    assign xr     = ext(iData);
    assign x1     = ext(s1);
    assign x2     = ext(s2);
    assign x3     = ext(s3);
    assign x4     = ext(s4);
    assign cntInc = cnt + 16'd1;

    // Binomial coefficients built from shifts and adds only.
    always_comb begin
        acc = xr;
        case (order)
            3'd1: acc = xr + x1;
            3'd2: acc = xr + (x1 <<< 1) - x2;
            3'd3: acc = xr + (x1 <<< 1) + x1 - (x2 <<< 1) - x2 + x3;
            3'd4: acc = xr + (x1 <<< 2) - (x2 <<< 2) - (x2 <<< 1)
                        + (x3 <<< 2) - x4;
            default: acc = xr;
        endcase
    end

`ifdef FIXED_PRED_SAT_EN
    localparam logic [SAMPLE_W-1:0] SMAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SMIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic accOvf;
    logic ovfQ;

    assign accOvf  = ~((&acc[ACC_W-1:SAMPLE_W-1]) | ~(|acc[ACC_W-1:SAMPLE_W-1]));
    assign predVal = accOvf ? (acc[ACC_W-1] ? SMIN : SMAX) : acc[SAMPLE_W-1:0];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            ovfQ <= 1'b0;
        end else if (predAccept && accOvf) begin
            ovfQ <= 1'b1;
        end
    end

    assign oOverflow = ovfQ;
`else
    logic unusedAccHi;

    assign unusedAccHi = ^acc[ACC_W-1:SAMPLE_W];
    assign predVal     = acc[SAMPLE_W-1:0];
    assign oOverflow   = 1'b0;
`endif

    assign predAccept = iEn && iValid && (state == PREDICT);

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        s1Next     = s1;
        s2Next     = s2;
        s3Next     = s3;
        s4Next     = s4;
        sampleNext = oSample;
        validNext  = 1'b0;
        doneNext   = 1'b0;
        errorNext  = oError;
        if (iEn) begin
            unique case (state)
                IDLE: begin
                    if (blockSize == 16'd0) begin
                        stateNext = DONE;
                        doneNext  = 1'b1;
                    end else if (order > 3'd4) begin
                        errorNext = 1'b1;
                        stateNext = DONE;
                        doneNext  = 1'b1;
                    end else if (order == 3'd0) begin
                        stateNext = PREDICT;
                    end else begin
                        stateNext = WARMUP;
                    end
                end
                WARMUP, PREDICT: begin
                    if (iValid) begin
                        sampleNext = (state == WARMUP) ? iData : predVal;
                        validNext  = 1'b1;
                        s1Next     = sampleNext;
                        s2Next     = s1;
                        s3Next     = s2;
                        s4Next     = s3;
                        cntNext    = cntInc;
                        if (cntInc == blockSize) begin
                            stateNext = DONE;
                            doneNext  = 1'b1;
                        end else if (state == WARMUP &&
                                     cntInc == {13'd0, order}) begin
                            stateNext = PREDICT;
                        end
                    end
                end
                DONE: begin
                    stateNext = DONE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= IDLE;
            order     <= iOrder;
            blockSize <= iBlockSize;
            cnt       <= 16'd0;
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            s4        <= '0;
            oSample   <= '0;
            oValid    <= 1'b0;
            oDone     <= 1'b0;
            oError    <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            s1        <= s1Next;
            s2        <= s2Next;
            s3        <= s3Next;
            s4        <= s4Next;
            oSample   <= sampleNext;
            oValid    <= validNext;
            oDone     <= doneNext;
            oError    <= errorNext;
        end
    end

endmodule

// File: tb/tb_fixed_predictor.sv
// Directed bench for fixed_predictor: table of subframes plus stall and
// mid-subframe reset sequences.
module tb_fixed_predictor;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iEn = 1'b0;
    logic [2:0]  iOrder = 3'd0;
    logic [15:0] iBlockSize = 16'd0;
    logic [15:0] iData = 16'd0;
    logic        iValid = 1'b0;
    logic [15:0] oSample;
    logic        oValid;
    logic        oDone;
    logic        oError;
    logic        oOverflow;

    int checks = 0;
    int errors = 0;

    fixed_predictor #(.SAMPLE_W(16), .ACC_W(20)) dut (
        .iClk(iClk),
        .iRst(iRst),
        .iEn(iEn),
        .iOrder(iOrder),
        .iBlockSize(iBlockSize),
        .iData(iData),
        .iValid(iValid),
        .oSample(oSample),
        .oValid(oValid),
        .oDone(oDone),
        .oError(oError),
        .oOverflow(oOverflow)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [2:0]        order;
        logic [15:0]       bs;
        logic [3:0]        n;
        logic [4:0][15:0]  data;
        logic [4:0][15:0]  exp;
        logic              expErr;
        logic              expOvf;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

`ifdef FIXED_PRED_SAT_EN
    localparam int SAT = 1;
`else
    localparam int SAT = 0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic setVec(input int idx, input int ord, input int bs, input int n,
                          input int d0, input int d1, input int d2, input int d3,
                          input int d4, input int e0, input int e1, input int e2,
                          input int e3, input int e4, input int err, input int ovf);
        vecs[idx].order   = 3'(ord);
        vecs[idx].bs      = 16'(bs);
        vecs[idx].n       = 4'(n);
        vecs[idx].data[0] = 16'(d0);
        vecs[idx].data[1] = 16'(d1);
        vecs[idx].data[2] = 16'(d2);
        vecs[idx].data[3] = 16'(d3);
        vecs[idx].data[4] = 16'(d4);
        vecs[idx].exp[0]  = 16'(e0);
        vecs[idx].exp[1]  = 16'(e1);
        vecs[idx].exp[2]  = 16'(e2);
        vecs[idx].exp[3]  = 16'(e3);
        vecs[idx].exp[4]  = 16'(e4);
        vecs[idx].expErr  = err[0];
        vecs[idx].expOvf  = ovf[0];
    endtask

    task automatic doReset(input int ord, input int bs);
        @(negedge iClk);
        iRst       = 1'b1;
        iEn        = 1'b1;
        iValid     = 1'b0;
        iOrder     = 3'(ord);
        iBlockSize = 16'(bs);
        @(negedge iClk);
        iRst = 1'b0;
        chk("rst_valid", int'(oValid), 0);
        chk("rst_done", int'(oDone), 0);
        chk("rst_sample", int'(oSample), 0);
        chk("rst_error", int'(oError), 0);
        chk("rst_ovf", int'(oOverflow), 0);
    endtask

    task automatic feed(input string name, input int d, input int exp,
                        input int last);
        iValid = 1'b1;
        iData  = 16'(d);
        @(negedge iClk);
        chk({name, "_valid"}, int'(oValid), 1);
        chk({name, "_sample"}, int'($signed(oSample)), exp);
        chk({name, "_done"}, int'(oDone), last);
    endtask

    task automatic stall(input string name, input int cycles, input int d);
        iEn    = 1'b0;
        iValid = 1'b1;
        iData  = 16'(d);
        for (int c = 0; c < cycles; c++) begin
            @(negedge iClk);
            chk({name, "_stall_valid"}, int'(oValid), 0);
            chk({name, "_stall_done"}, int'(oDone), 0);
        end
        iEn = 1'b1;
    endtask

    initial begin
        setVec(0, 2, 5, 5, 10, 20, 0, 0, 1, 10, 20, 30, 40, 51, 0, 0);
        setVec(1, 4, 5, 5, 1, 2, 3, 4, 0, 1, 2, 3, 4, 5, 0, 0);
        setVec(2, 0, 2, 2, -7, 9, 0, 0, 0, -7, 9, 0, 0, 0, 0, 0);
        setVec(3, 1, 2, 2, 32767, 1, 0, 0, 0, 32767,
               SAT ? 32767 : -32768, 0, 0, 0, 0, SAT);
        setVec(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        setVec(5, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        setVec(6, 3, 2, 2, 4, 6, 0, 0, 0, 4, 6, 0, 0, 0, 0, 0);
        setVec(7, 3, 4, 4, 1, 2, 3, 0, 0, 1, 2, 3, 4, 0, 0, 0);
        setVec(8, 1, 4, 4, 100, -50, -50, -50, 0, 100, 50, 0, -50, 0, 0, 0);

        for (int v = 0; v < NV; v++) begin
            string nm;
            nm = $sformatf("v%0d", v);
            doReset(int'(vecs[v].order), int'(vecs[v].bs));
            @(negedge iClk);
            chk({nm, "_idle_valid"}, int'(oValid), 0);
            chk({nm, "_idle_done"}, int'(oDone), (vecs[v].n == 0) ? 1 : 0);
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                feed($sformatf("%s_s%0d", nm, k),
                     int'($signed(vecs[v].data[k])),
                     int'($signed(vecs[v].exp[k])),
                     (k == int'(vecs[v].n) - 1) ? 1 : 0);
            end
            iValid = 1'b1;
            iData  = 16'd99;
            @(negedge iClk);
            chk({nm, "_after_valid"}, int'(oValid), 0);
            chk({nm, "_after_done"}, int'(oDone), 0);
            chk({nm, "_error"}, int'(oError), int'(vecs[v].expErr));
            chk({nm, "_ovf"}, int'(oOverflow), int'(vecs[v].expOvf));
            iValid = 1'b0;
        end

        doReset(1, 3);
        @(negedge iClk);
        feed("st0", 5, 5, 0);
        stall("st1", 2, 3);
        feed("st1", 3, 8, 0);
        stall("st2", 2, -2);
        feed("st2", -2, 6, 1);
        iValid = 1'b0;

        doReset(2, 5);
        @(negedge iClk);
        feed("mr0", 10, 10, 0);
        feed("mr1", 20, 20, 0);
        feed("mr2", 0, 30, 0);
        doReset(1, 2);
        @(negedge iClk);
        chk("mr_idle_done", int'(oDone), 0);
        feed("mr3", 7, 7, 0);
        feed("mr4", 1, 8, 1);
        iValid = 1'b0;
        @(negedge iClk);
        chk("mr_end_done", int'(oDone), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
